// File: rtl/lbist_controller_pkg.sv
// Shared LBIST definitions: session state encoding and default widths.
// Also intended for the future LFSR/MISR top-level wrapper.
package lbist_controller_pkg;

    // Default widths of the signature and pattern counter.
    localparam int DEF_SIG_W = 8;
    localparam int DEF_CNT_W = 8;

    // Session sequencer states (3-bit encoding, stable across blocks).
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // A session is in progress in every state between leaving IDLE and reaching DONE.
    function automatic logic is_busy_state(input state_t s);
        return (s == ST_INIT) || (s == ST_RUN) || (s == ST_FLUSH) || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/lbist_controller_if.sv
// Host and datapath signal bundle of the LBIST session controller.
interface lbist_controller_if
    import lbist_controller_pkg::*;
#(
    parameter int SIG_W = DEF_SIG_W,
    parameter int CNT_W = DEF_CNT_W
);

    // Host handshake: start is a level request, only looked at while the
    // controller is idle or done. busy is high from the cycle after start is
    // taken until the result is ready; done then stays high with pass/fail
    // valid until the next start is taken. abort is a level that beats start
    // in every state and returns the controller to idle on the next edge.
    logic             start;
    logic             abort;
    logic [SIG_W-1:0] golden_sig;
    logic             busy;
    logic             done;
    logic             pass;
    logic             fail;
    logic [CNT_W-1:0] pattern_cnt;

    // Datapath control and signature return.
    logic [SIG_W-1:0] misr_sig;
    logic             lfsr_load;
    logic             lfsr_en;
    logic             misr_clr;
    logic             misr_en;

    // Controller side.
    modport slave (
        input  start, abort, golden_sig, misr_sig,
        output lfsr_load, lfsr_en, misr_clr, misr_en,
        output busy, done, pass, fail, pattern_cnt
    );

    // Host / datapath side.
    modport master (
        output start, abort, golden_sig, misr_sig,
        input  lfsr_load, lfsr_en, misr_clr, misr_en,
        input  busy, done, pass, fail, pattern_cnt
    );

endinterface

// File: rtl/lbist_controller_delay_line.sv
// Delay line that lines MISR compaction up with the buffer/CUT pipeline.
// A DEPTH-deep 1-bit shift register: the output is the input delayed exactly
// DEPTH cycles, and the empty flag says no pattern is still in flight.
module lbist_controller_delay_line #(
    parameter int DEPTH = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_din,
    output logic o_dout,
    output logic o_empty
);

    logic [DEPTH-1:0] r_sr;

    // Shift in one bit per cycle; sync clear drops every in-flight pattern.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sr <= '0;
        end else if (i_clr) begin
            r_sr <= '0;
        end else begin
            // Keeping the low DEPTH bits of {r_sr, i_din} also covers DEPTH == 1.
            r_sr <= DEPTH'({r_sr, i_din});
        end
    end

    assign o_dout  = r_sr[DEPTH-1];
    assign o_empty = ~|r_sr;

endmodule

// File: rtl/lbist_controller.sv
// LBIST session sequencer: seeds the LFSR, clears the MISR, applies
// NUM_PATTERNS patterns, waits for the pipeline to drain into the MISR and
// compares the final signature with the golden value.
module lbist_controller
    import lbist_controller_pkg::*;
#(
    parameter int SIG_W        = DEF_SIG_W,
    parameter int NUM_PATTERNS = 200,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int PIPE_LAT     = 2
) (
    input  logic               clk,
    input  logic               rst,
    lbist_controller_if.slave  lbist,
    output state_t             o_dbg_state
);

    // The counter carries one extra bit so a full 2^CNT_W session does not
    // wrap back to zero when it reaches NUM_PATTERNS.
    localparam logic [CNT_W:0] LAST_CNT = (CNT_W + 1)'(NUM_PATTERNS - 1);

    state_t         r_state;
    state_t         w_next_state;
    logic [CNT_W:0] r_cnt;
    logic           r_lfsr_load;
    logic           r_misr_clr;
    logic           r_lfsr_en;
    logic           r_busy;
    logic           r_done;
    logic           r_pass;
    logic           r_fail;
    logic           w_misr_en;
    logic           w_dl_empty;
    logic           w_sig_match;

    assign w_sig_match = (lbist.misr_sig == lbist.golden_sig);

    // Next-state decode; abort wins over everything, including start.
    always_comb begin
        w_next_state = r_state;
        if (lbist.abort) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (lbist.start) w_next_state = ST_INIT;
                ST_INIT:  w_next_state = ST_RUN;
                ST_RUN:   if (r_cnt == LAST_CNT) w_next_state = ST_FLUSH;
                ST_FLUSH: if (w_dl_empty) w_next_state = ST_CHECK;
                ST_CHECK: w_next_state = ST_DONE;
                ST_DONE:  if (lbist.start) w_next_state = ST_INIT;
                default:  w_next_state = ST_IDLE;
            endcase
        end
    end

    // State register plus every control output, registered from the next state
    // so the outputs line up with the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_lfsr_load <= 1'b0;
            r_misr_clr  <= 1'b0;
            r_lfsr_en   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_lfsr_load <= (w_next_state == ST_INIT);
            r_misr_clr  <= (w_next_state == ST_INIT);
            r_lfsr_en   <= (w_next_state == ST_RUN);
            r_busy      <= is_busy_state(w_next_state);
            r_done      <= (w_next_state == ST_DONE);

            // Count patterns only while they are being issued; hold afterwards.
            if (w_next_state inside {ST_IDLE, ST_INIT}) begin
                r_cnt <= '0;
            end else if (r_state == ST_RUN) begin
                r_cnt <= r_cnt + 1'b1;
            end

            // Result is captured leaving CHECK, held through DONE, zero elsewhere.
            if (r_state == ST_CHECK && w_next_state == ST_DONE) begin
                r_pass <= w_sig_match;
                r_fail <= !w_sig_match;
            end else if (w_next_state != ST_DONE) begin
                r_pass <= 1'b0;
                r_fail <= 1'b0;
            end
        end
    end

    // lfsr_en delayed by the pipeline latency becomes the MISR enable.
    lbist_controller_delay_line #(
        .DEPTH (PIPE_LAT)
    ) u_delay_line (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_clr   (lbist.abort),
        .i_din   (r_lfsr_en),
        .o_dout  (w_misr_en),
        .o_empty (w_dl_empty)
    );

    assign lbist.lfsr_load   = r_lfsr_load;
    assign lbist.misr_clr    = r_misr_clr;
    assign lbist.lfsr_en     = r_lfsr_en;
    assign lbist.misr_en     = w_misr_en;
    assign lbist.busy        = r_busy;
    assign lbist.done        = r_done;
    assign lbist.pass        = r_pass;
    assign lbist.fail        = r_fail;
    assign lbist.pattern_cnt = r_cnt[CNT_W] ? {CNT_W{1'b1}} : r_cnt[CNT_W-1:0];
    assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_lbist_controller.sv
// Bench for lbist_controller: three instances with different pattern counts
// and pipeline latencies share one stimulus stream and are each compared
// against a timeline model of an LBIST session every cycle.
module tb_lbist_controller;
    import lbist_controller_pkg::*;

    localparam int NDUT   = 3;
    localparam int M_IDLE = 0;
    localparam int M_SESS = 1;
    localparam int M_DONE = 2;

    // Clock and reset.
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Shared stimulus.
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] golden_sig = 8'h00;
    logic [7:0] misr_sig = 8'h00;

    lbist_controller_if #(.SIG_W(8), .CNT_W(8)) if_a ();
    lbist_controller_if #(.SIG_W(8), .CNT_W(8)) if_b ();
    lbist_controller_if #(.SIG_W(8), .CNT_W(4)) if_c ();

    assign if_a.start = start;  assign if_a.abort = abort;
    assign if_a.golden_sig = golden_sig;  assign if_a.misr_sig = misr_sig;
    assign if_b.start = start;  assign if_b.abort = abort;
    assign if_b.golden_sig = golden_sig;  assign if_b.misr_sig = misr_sig;
    assign if_c.start = start;  assign if_c.abort = abort;
    assign if_c.golden_sig = golden_sig;  assign if_c.misr_sig = misr_sig;

    state_t st_a, st_b, st_c;

    lbist_controller #(.SIG_W(8), .NUM_PATTERNS(4), .CNT_W(8), .PIPE_LAT(2)) dut_a (
        .clk(clk), .rst(rst), .lbist(if_a), .o_dbg_state(st_a));
    lbist_controller #(.SIG_W(8), .NUM_PATTERNS(1), .CNT_W(8), .PIPE_LAT(1)) dut_b (
        .clk(clk), .rst(rst), .lbist(if_b), .o_dbg_state(st_b));
    lbist_controller #(.SIG_W(8), .NUM_PATTERNS(9), .CNT_W(4), .PIPE_LAT(3)) dut_c (
        .clk(clk), .rst(rst), .lbist(if_c), .o_dbg_state(st_c));

    int p_n    [NDUT] = '{4, 1, 9};
    int p_pl   [NDUT] = '{2, 1, 3};
    int p_cmax [NDUT] = '{255, 255, 15};

    // Model: idle, in a session t cycles after INIT began, or done with a result.
    int m_mode [NDUT];
    int m_t    [NDUT];
    bit m_pass [NDUT];
    bit m_fail [NDUT];

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int k, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d at %0t: got %0d expected %0d", name, k, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < NDUT; k++) begin
            m_mode[k] = M_IDLE;
            m_t[k]    = 0;
            m_pass[k] = 1'b0;
            m_fail[k] = 1'b0;
        end
    endfunction

    // One clock edge of the session rules, using the inputs seen at that edge.
    task automatic model_step();
        for (int k = 0; k < NDUT; k++) begin
            if (rst || abort) begin
                m_mode[k] = M_IDLE;
                m_t[k]    = 0;
                m_pass[k] = 1'b0;
                m_fail[k] = 1'b0;
            end else if (m_mode[k] == M_IDLE || m_mode[k] == M_DONE) begin
                if (start) begin
                    m_mode[k] = M_SESS;
                    m_t[k]    = 0;
                    m_pass[k] = 1'b0;
                    m_fail[k] = 1'b0;
                end
            end else if (m_t[k] == p_n[k] + p_pl[k] + 2) begin
                m_mode[k] = M_DONE;
                m_pass[k] = (misr_sig == golden_sig);
                m_fail[k] = (misr_sig != golden_sig);
            end else begin
                m_t[k]++;
            end
        end
    endtask

    task automatic get_obs(input int k, output int load, output int clr, output int len,
                           output int men, output int busy, output int done, output int pass,
                           output int fail, output int cnt, output int st);
        case (k)
            0: begin
                load = int'(if_a.lfsr_load); clr = int'(if_a.misr_clr); len = int'(if_a.lfsr_en);
                men = int'(if_a.misr_en); busy = int'(if_a.busy); done = int'(if_a.done);
                pass = int'(if_a.pass); fail = int'(if_a.fail); cnt = int'(if_a.pattern_cnt);
                st = int'(st_a);
            end
            1: begin
                load = int'(if_b.lfsr_load); clr = int'(if_b.misr_clr); len = int'(if_b.lfsr_en);
                men = int'(if_b.misr_en); busy = int'(if_b.busy); done = int'(if_b.done);
                pass = int'(if_b.pass); fail = int'(if_b.fail); cnt = int'(if_b.pattern_cnt);
                st = int'(st_b);
            end
            default: begin
                load = int'(if_c.lfsr_load); clr = int'(if_c.misr_clr); len = int'(if_c.lfsr_en);
                men = int'(if_c.misr_en); busy = int'(if_c.busy); done = int'(if_c.done);
                pass = int'(if_c.pass); fail = int'(if_c.fail); cnt = int'(if_c.pattern_cnt);
                st = int'(st_c);
            end
        endcase
    endtask

    // Scoreboard compare of every instance against the model.
    task automatic cmp_all();
        int load, clr, len, men, busy, done, pass, fail, cnt, st;
        int e_load, e_len, e_men, e_busy, e_done, e_pass, e_fail, e_cnt, t;
        for (int k = 0; k < NDUT; k++) begin
            get_obs(k, load, clr, len, men, busy, done, pass, fail, cnt, st);
            e_load = 0; e_len = 0; e_men = 0; e_busy = 0;
            e_done = 0; e_pass = 0; e_fail = 0; e_cnt = 0;
            if (m_mode[k] == M_SESS) begin
                t      = m_t[k];
                e_load = (t == 0) ? 1 : 0;
                e_len  = (t >= 1 && t <= p_n[k]) ? 1 : 0;
                e_men  = (t >= p_pl[k] + 1 && t <= p_n[k] + p_pl[k]) ? 1 : 0;
                e_busy = 1;
                e_cnt  = (t < 1) ? 0 : ((t - 1 > p_n[k]) ? p_n[k] : t - 1);
            end else if (m_mode[k] == M_DONE) begin
                e_done = 1;
                e_pass = int'(m_pass[k]);
                e_fail = int'(m_fail[k]);
                e_cnt  = p_n[k];
            end
            if (e_cnt > p_cmax[k]) e_cnt = p_cmax[k];
            chk("lfsr_load", k, load, e_load);
            chk("misr_clr", k, clr, e_load);
            chk("lfsr_en", k, len, e_len);
            chk("misr_en", k, men, e_men);
            chk("busy", k, busy, e_busy);
            chk("done", k, done, e_done);
            chk("pass", k, pass, e_pass);
            chk("fail", k, fail, e_fail);
            chk("pattern_cnt", k, cnt, e_cnt);
        end
    endtask

    // Compare process: model advances on each edge, outputs checked 2 time units later.
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            model_step();
            #2;
            if (chk_en) cmp_all();
        end
    end

    // Asynchronous reset clears the model at once, like the design.
    always @(posedge rst) model_reset();

    // Literal check that one instance shows the reset/idle output values.
    task automatic chk_idle(input int k, input string tag);
        int load, clr, len, men, busy, done, pass, fail, cnt, st;
        get_obs(k, load, clr, len, men, busy, done, pass, fail, cnt, st);
        chk({tag, "_outs"}, k, load | clr | len | men | busy | done | pass | fail, 0);
        chk({tag, "_cnt"}, k, cnt, 0);
        chk({tag, "_state"}, k, st, int'(ST_IDLE));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Edges from the start edge until instance A reports done, bounded.
    task automatic wait_done_a(output int edges);
        edges = 1;
        while (!if_a.done && edges < 60) begin
            step();
            edges++;
        end
    endtask

    // Directed scenarios followed by randomized traffic.
    initial begin
        logic [17:0] ta_load, ta_len, ta_men, ta_done;
        logic [17:0] tb_len, tb_men, tb_done, tc_len, tc_done;
        int load, clr, len, men, busy, done, pass, fail, cnt, st;
        int edges;

        ta_load = 18'h00002; ta_len = 18'h0003C; ta_men = 18'h000F0; ta_done = 18'h3FC00;
        tb_len  = 18'h00004; tb_men = 18'h00008; tb_done = 18'h3FFC0;
        tc_len  = 18'h007FC; tc_done = 18'h30000;

        // Reset state.
        rst = 1'b1;
        repeat (3) step();
        for (int k = 0; k < NDUT; k++) chk_idle(k, "reset");
        rst = 1'b0;
        chk_en = 1'b1;

        // Nominal pass session; start sampled at edge 1.
        golden_sig = 8'hA5;
        misr_sig   = 8'hA5;
        start      = 1'b1;
        for (int e = 1; e <= 17; e++) begin
            step();
            if (e == 1) start = 1'b0;
            get_obs(0, load, clr, len, men, busy, done, pass, fail, cnt, st);
            chk("tbl_lfsr_load", 0, load, int'(ta_load[e]));
            chk("tbl_lfsr_en", 0, len, int'(ta_len[e]));
            chk("tbl_misr_en", 0, men, int'(ta_men[e]));
            chk("tbl_done", 0, done, int'(ta_done[e]));
            if (e == 10) begin
                chk("nominal_pass", 0, pass, 1);
                chk("nominal_cnt", 0, cnt, 4);
            end
            get_obs(1, load, clr, len, men, busy, done, pass, fail, cnt, st);
            chk("tbl_lfsr_en", 1, len, int'(tb_len[e]));
            chk("tbl_misr_en", 1, men, int'(tb_men[e]));
            chk("tbl_done", 1, done, int'(tb_done[e]));
            get_obs(2, load, clr, len, men, busy, done, pass, fail, cnt, st);
            chk("tbl_lfsr_en", 2, len, int'(tc_len[e]));
            chk("tbl_done", 2, done, int'(tc_done[e]));
        end

        // Signature mismatch.
        golden_sig = 8'h3C;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done_a(edges);
        chk("mismatch_latency", 0, edges, 10);
        get_obs(0, load, clr, len, men, busy, done, pass, fail, cnt, st);
        chk("mismatch_fail", 0, fail, 1);
        chk("mismatch_pass", 0, pass, 0);
        chk("mismatch_cnt", 0, cnt, 4);
        repeat (8) step();

        // Abort on the first FLUSH cycle of instance A.
        abort = 1'b1;
        step();
        abort = 1'b0;
        golden_sig = 8'hA5;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        get_obs(0, load, clr, len, men, busy, done, pass, fail, cnt, st);
        chk("flush_state", 0, st, int'(ST_FLUSH));
        chk("flush_misr_en", 0, men, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        get_obs(0, load, clr, len, men, busy, done, pass, fail, cnt, st);
        chk("abort_misr_en", 0, men, 0);
        chk("abort_busy", 0, busy, 0);
        chk("abort_done", 0, done, 0);
        chk("abort_state", 0, st, int'(ST_IDLE));
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done_a(edges);
        chk("post_abort_latency", 0, edges, 10);
        chk("post_abort_pass", 0, int'(if_a.pass), 1);
        repeat (8) step();

        // Back-to-back sessions with start held high.
        start = 1'b1;
        step();
        wait_done_a(edges);
        chk("b2b_first_latency", 0, edges, 10);
        step();
        get_obs(0, load, clr, len, men, busy, done, pass, fail, cnt, st);
        chk("b2b_done_width", 0, done, 0);
        chk("b2b_reinit_load", 0, load, 1);
        chk("b2b_reinit_clr", 0, clr, 1);
        chk("b2b_pass_cleared", 0, pass | fail, 0);
        chk("b2b_busy", 0, busy, 1);
        wait_done_a(edges);
        chk("b2b_second_latency", 0, edges, 10);
        start = 1'b0;
        repeat (20) step();

        // Asynchronous reset in the middle of RUN on instance C.
        abort = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        chk("midrun_cnt", 2, int'(if_c.pattern_cnt), 5);
        #3;
        rst = 1'b1;
        #1;
        for (int k = 0; k < NDUT; k++) chk_idle(k, "async_rst");
        step();
        rst = 1'b0;
        repeat (20) step();
        chk("no_done_after_rst", 2, int'(if_c.done), 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step();
            rst        = ($urandom_range(0, 399) == 0);
            abort      = ($urandom_range(0, 59) == 0);
            start      = ($urandom_range(0, 2) == 0);
            misr_sig   = 8'($urandom);
            golden_sig = ($urandom_range(0, 1) == 1) ? misr_sig : 8'($urandom);
        end
        rst   = 1'b0;
        abort = 1'b0;
        start = 1'b0;
        repeat (5) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
